// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter for sixteen stations sharing one serial bus line. When
// idle it picks the next requester after the previous winner, latches that
// station's frame (muxed externally by grant_id) and shifts it out MSB first
// as a 77-bit serial frame, followed by a one-cycle gap in which the winner
// receives a one-hot ack pulse.
//
// Serial frame: start bit (1), source id[3:0], dest addr[3:0],
//               data[63:0], crc[3:0]  -- each field MSB first.
//
// Ports
//   clock        : system clock, all state changes on its rising edge
//   reset        : synchronous active-high reset
//   req[15:0]    : per-station frame-pending request
//   frame_addr   : destination address of the granted station
//   frame_data   : 64-bit payload of the granted station
//   frame_crc    : 4-bit CRC of the granted station
//   grant_id     : index of the station that owns the bus
//   grant_valid  : grant_id is meaningful
//   ack[15:0]    : one-hot, one-cycle completion pulse
//   busy         : arbiter is not idle
//   bus_show     : registered serial bus line
// ---------------------------------------------------------------------------
module bus_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic [3:0]  frame_addr,
    input  logic [63:0] frame_data,
    input  logic [3:0]  frame_crc,
    output logic [3:0]  grant_id,
    output logic        grant_valid,
    output logic [15:0] ack,
    output logic        busy,
    output logic        bus_show
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int FRAME_BITS = 77;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shreg;
    logic [6:0]              bit_cnt;
    logic [3:0]              last_winner;
    logic [3:0]              winner;
    logic [3:0]              idx;
    logic                    found;

    // Round-robin search starting one past the previous winner. The offset
    // runs 1..16, so its low four bits wrap to 0 on the last step, which
    // makes last_winner itself the lowest-priority candidate.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = last_winner + k[3:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Single FSM: all outputs are registered here. ack defaults to zero each
    // cycle so that the pulse set in GAP lasts exactly one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bus_show    <= 1'b0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            last_winner <= 4'hF;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    bus_show    <= 1'b0;
                    grant_valid <= 1'b0;
                    busy        <= 1'b0;
                    if (|req) begin
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                // The frame inputs are only looked at here; later changes
                // cannot disturb a frame already in flight.
                LOAD: begin
                    shreg   <= {1'b1, grant_id, frame_addr, frame_data, frame_crc};
                    bit_cnt <= '0;
                    state   <= SEND;
                end
                SEND: begin
                    bus_show <= shreg[FRAME_BITS-1];
                    shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
                    bit_cnt  <= bit_cnt + 7'd1;
                    if (bit_cnt == 7'(FRAME_BITS - 1)) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    bus_show    <= 1'b0;
                    ack         <= 16'h0001 << grant_id;
                    last_winner <= grant_id;
                    grant_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed testbench for bus_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge. "After Ek" below means the falling edge that
// follows rising edge k, where E0 is the edge that samples a new request.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clock;
    logic        reset;
    logic [15:0] req;
    logic [3:0]  frame_addr;
    logic [63:0] frame_data;
    logic [3:0]  frame_crc;
    logic [3:0]  grant_id;
    logic        grant_valid;
    logic [15:0] ack;
    logic        busy;
    logic        bus_show;

    int checks;
    int passes;

    bus_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .frame_addr  (frame_addr),
        .frame_data  (frame_data),
        .frame_crc   (frame_crc),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .ack         (ack),
        .busy        (busy),
        .bus_show    (bus_show)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n falling edges.
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step(2);
        reset = 1'b0;
    endtask

    // Called right after E0. Collects the 77 serial bits (after E2..E78) and
    // the outputs after E79. At bit index mod_bit, frame_data and req are
    // overwritten; after the last bit (i.e. during GAP) req is set to
    // gap_req when gap_en is high.
    task automatic capture_frame(
        input  int          mod_bit,
        input  logic [63:0] mod_data,
        input  logic [15:0] mod_req,
        input  logic        gap_en,
        input  logic [15:0] gap_req,
        output logic [76:0] bits,
        output logic        early_ack,
        output logic [15:0] ack_out,
        output logic        gv_out,
        output logic        busy_out
    );
        bits      = '0;
        early_ack = 1'b0;
        step(1);
        for (int i = 0; i < 77; i++) begin
            step(1);
            bits[76-i] = bus_show;
            if (ack !== 16'h0000) early_ack = 1'b1;
            if (i == mod_bit) begin
                frame_data = mod_data;
                req        = mod_req;
            end
            if (i == 76 && gap_en) req = gap_req;
        end
        step(1);
        ack_out  = ack;
        gv_out   = grant_valid;
        busy_out = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '0; frame_addr = '0; frame_data = '0; frame_crc = '0;
        step(2);
        checks++;
        if ({grant_id, grant_valid, ack, busy, bus_show} !== 23'd0)
            $display("[TB] FAIL reset_outputs: got gid=%h gv=%b ack=%h busy=%b bus=%b, expected all zero",
                     grant_id, grant_valid, ack, busy, bus_show);
        else passes++;
        reset = 1'b0;
        step(3);
        checks++;
        if ({grant_valid, busy} !== 2'b00)
            $display("[TB] FAIL reset_idle_hold: got gv=%b busy=%b, expected 0 0", grant_valid, busy);
        else passes++;
    endtask

    task automatic test_single_frame();
        logic [76:0] bits, exp_bits;
        logic        early, gv_o, busy_o;
        logic [15:0] ack_o;
        do_reset();
        frame_addr = 4'd1; frame_data = 64'd1; frame_crc = 4'd1;
        exp_bits = {1'b1, 4'd0, 4'd1, 64'd1, 4'd1};
        req = 16'h0001;
        step(1);
        checks++;
        if ({grant_id, grant_valid, busy} !== {4'd0, 1'b1, 1'b1})
            $display("[TB] FAIL single_grant: got gid=%0d gv=%b busy=%b, expected 0 1 1",
                     grant_id, grant_valid, busy);
        else passes++;
        req = 16'h0000;
        capture_frame(-1, '0, '0, 1'b0, '0, bits, early, ack_o, gv_o, busy_o);
        checks++;
        if (bits !== exp_bits)
            $display("[TB] FAIL single_bits: got %h expected %h", bits, exp_bits);
        else passes++;
        checks++;
        if (early !== 1'b0)
            $display("[TB] FAIL single_early_ack: got early ack, expected none");
        else passes++;
        checks++;
        if ({ack_o, gv_o, busy_o} !== {16'h0001, 1'b0, 1'b0})
            $display("[TB] FAIL single_ack: got ack=%h gv=%b busy=%b, expected 0001 0 0", ack_o, gv_o, busy_o);
        else passes++;
        step(1);
        checks++;
        if ({ack, grant_valid} !== {16'h0000, 1'b0})
            $display("[TB] FAIL single_ack_width: got ack=%h gv=%b, expected 0000 0", ack, grant_valid);
        else passes++;
    endtask

    task automatic test_fairness();
        logic [15:0] exp_ack;
        do_reset();
        frame_addr = 4'hA; frame_data = 64'h0123_4567_89AB_CDEF; frame_crc = 4'h5;
        req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            step(1);
            checks++;
            if ({grant_id, grant_valid} !== {4'(k % 16), 1'b1})
                $display("[TB] FAIL fair_grant_%0d: got gid=%0d gv=%b, expected %0d 1",
                         k, grant_id, grant_valid, k % 16);
            else passes++;
            if (k < 16) begin
                step(79);
                exp_ack = 16'h0001 << (k % 16);
                checks++;
                if ({ack, grant_valid} !== {exp_ack, 1'b0})
                    $display("[TB] FAIL fair_ack_%0d: got ack=%h gv=%b, expected %h 0",
                             k, ack, grant_valid, exp_ack);
                else passes++;
            end
        end
        req = '0;
    endtask

    task automatic test_rotation();
        do_reset();
        frame_addr = 4'h3; frame_data = 64'hFFFF_0000_FFFF_0000; frame_crc = 4'h9;
        req = 16'h0008;
        step(1);
        checks++;
        if ({grant_id, grant_valid} !== {4'd3, 1'b1})
            $display("[TB] FAIL rot_prime: got gid=%0d gv=%b, expected 3 1", grant_id, grant_valid);
        else passes++;
        req = 16'h0208;
        step(79);
        checks++;
        if (ack !== 16'h0008)
            $display("[TB] FAIL rot_prime_ack: got %h expected 0008", ack);
        else passes++;
        step(1);
        checks++;
        if ({grant_id, grant_valid} !== {4'd9, 1'b1})
            $display("[TB] FAIL rot_first: got gid=%0d gv=%b, expected 9 1", grant_id, grant_valid);
        else passes++;
        step(79);
        checks++;
        if (ack !== 16'h0200)
            $display("[TB] FAIL rot_first_ack: got %h expected 0200", ack);
        else passes++;
        step(1);
        checks++;
        if ({grant_id, grant_valid} !== {4'd3, 1'b1})
            $display("[TB] FAIL rot_second: got gid=%0d gv=%b, expected 3 1", grant_id, grant_valid);
        else passes++;
        req = '0;
    endtask

    task automatic test_reset_mid_frame();
        int ack_seen;
        do_reset();
        frame_addr = 4'hF; frame_data = '1; frame_crc = 4'hF;
        req = 16'h0001;
        step(1);
        step(79);
        checks++;
        if (ack !== 16'h0001)
            $display("[TB] FAIL rmf_prime_ack: got %h expected 0001", ack);
        else passes++;
        req = 16'h8001;
        step(1);
        checks++;
        if ({grant_id, grant_valid} !== {4'd15, 1'b1})
            $display("[TB] FAIL rmf_grant15: got gid=%0d gv=%b, expected 15 1", grant_id, grant_valid);
        else passes++;
        step(41);
        checks++;
        if (bus_show !== 1'b1)
            $display("[TB] FAIL rmf_bit39: got %b expected 1", bus_show);
        else passes++;
        reset = 1'b1;
        step(1);
        checks++;
        if ({bus_show, busy, grant_valid, ack} !== 19'd0)
            $display("[TB] FAIL rmf_after_reset: got bus=%b busy=%b gv=%b ack=%h, expected all zero",
                     bus_show, busy, grant_valid, ack);
        else passes++;
        reset = 1'b0;
        step(1);
        checks++;
        if ({grant_id, grant_valid} !== {4'd0, 1'b1})
            $display("[TB] FAIL rmf_regrant: got gid=%0d gv=%b, expected 0 1", grant_id, grant_valid);
        else passes++;
        req = '0;
        ack_seen = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (ack !== 16'h0000) ack_seen++;
        end
        checks++;
        if (ack_seen !== 0)
            $display("[TB] FAIL rmf_no_ack: got %0d ack cycles, expected 0", ack_seen);
        else passes++;
    endtask

    task automatic test_req_change();
        logic [76:0] bits, exp_bits;
        logic        early, gv_o, busy_o;
        logic [15:0] ack_o;
        do_reset();
        // Destination equals source id: still transmitted unchanged.
        frame_addr = 4'd2; frame_data = 64'hDEAD_BEEF_CAFE_F00D; frame_crc = 4'hC;
        exp_bits = {1'b1, 4'd2, 4'd2, 64'hDEAD_BEEF_CAFE_F00D, 4'hC};
        req = 16'h0004;
        step(1);
        checks++;
        if (grant_id !== 4'd2)
            $display("[TB] FAIL chg_grant: got %0d expected 2", grant_id);
        else passes++;
        capture_frame(10, frame_data, 16'h0000, 1'b1, 16'h0020,
                      bits, early, ack_o, gv_o, busy_o);
        checks++;
        if (bits !== exp_bits)
            $display("[TB] FAIL chg_bits: got %h expected %h", bits, exp_bits);
        else passes++;
        checks++;
        if ({ack_o, gv_o} !== {16'h0004, 1'b0})
            $display("[TB] FAIL chg_ack: got ack=%h gv=%b, expected 0004 0", ack_o, gv_o);
        else passes++;
        step(1);
        checks++;
        if ({grant_id, grant_valid} !== {4'd5, 1'b1})
            $display("[TB] FAIL chg_gap_req: got gid=%0d gv=%b, expected 5 1", grant_id, grant_valid);
        else passes++;
        req = '0;
    endtask

    task automatic test_isolation();
        logic [76:0] bits, exp_bits;
        logic        early, gv_o, busy_o;
        logic [15:0] ack_o;
        do_reset();
        frame_addr = 4'h6; frame_data = 64'hA5A5_5A5A_0F0F_F0F0; frame_crc = 4'h3;
        exp_bits = {1'b1, 4'd1, 4'h6, 64'hA5A5_5A5A_0F0F_F0F0, 4'h3};
        req = 16'h0002;
        step(1);
        capture_frame(20, 64'h5A5A_A5A5_F0F0_0F0F, 16'h0000, 1'b0, '0,
                      bits, early, ack_o, gv_o, busy_o);
        checks++;
        if (bits !== exp_bits)
            $display("[TB] FAIL iso_bits: got %h expected %h", bits, exp_bits);
        else passes++;
        checks++;
        if (ack_o !== 16'h0002)
            $display("[TB] FAIL iso_ack: got %h expected 0002", ack_o);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_single_frame();
        test_fairness();
        test_rotation();
        test_reset_mid_frame();
        test_req_change();
        test_isolation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
